// File: rtl/alarm_clock_controller_if.sv
// ---------------------------------------------------------------------------
// alarm_clock_controller_if
// Groups the pulse/level inputs and the display/status outputs of the
// alarm clock controller. The clock and reset stay plain ports on the
// controller.
//   master : drives en_1hz, btn_*, alarm_en; observes disp_*, sel, status
//   slave  : the controller side (inputs and outputs reversed)
// ---------------------------------------------------------------------------
interface alarm_clock_controller_if;
  logic       en_1hz;
  logic       btn_center;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       alarm_en;
  logic [4:0] disp_hours;
  logic [5:0] disp_minutes;
  logic [5:0] disp_seconds;
  logic       adjust_mode;
  logic [1:0] sel;
  logic       alarm_active;

  modport master (
    output en_1hz, btn_center, btn_up, btn_down, btn_left, btn_right, alarm_en,
    input  disp_hours, disp_minutes, disp_seconds, adjust_mode, sel, alarm_active
  );

  modport slave (
    input  en_1hz, btn_center, btn_up, btn_down, btn_left, btn_right, alarm_en,
    output disp_hours, disp_minutes, disp_seconds, adjust_mode, sel, alarm_active
  );
endinterface

// File: rtl/alarm_clock_controller.sv
// ---------------------------------------------------------------------------
// alarm_clock_controller
// Mode / time-keeping FSM for an alarm clock (states CLOCK, ADJUST, ALARM).
// Ports:
//   clock : system clock (single domain)
//   rst   : synchronous, active-high reset
//   bus   : alarm_clock_controller_if.slave
//           in : en_1hz (1 Hz pulse), btn_* (one-cycle button pulses),
//                alarm_en (level, arms the alarm)
//           out: disp_hours/minutes/seconds, adjust_mode, sel, alarm_active
// All outputs are registered: an input event in cycle N shows in cycle N+1.
// ---------------------------------------------------------------------------
module alarm_clock_controller #(
  parameter int unsigned ALARM_SECONDS = 60
) (
  input logic                     clock,
  input logic                     rst,
  alarm_clock_controller_if.slave bus
);

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SECONDS);

  typedef enum logic [1:0] {
    ST_CLOCK  = 2'd0,
    ST_ADJUST = 2'd1,
    ST_ALARM  = 2'd2
  } state_e;

  // Field helpers: wrap without carrying into neighbouring fields.
  function automatic logic [4:0] hr_inc(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [4:0] hr_dec(input logic [4:0] h);
    return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_inc(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [5:0] min_dec(input logic [5:0] m);
    return (m == 6'd0 || m > 6'd59) ? 6'd59 : m - 6'd1;
  endfunction

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic [5:0] al_min_q, al_min_d;
  logic [4:0] al_hr_q, al_hr_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] timer_q, timer_d;

  logic [4:0] disp_hours_q, disp_hours_d;
  logic [5:0] disp_minutes_q, disp_minutes_d;
  logic [5:0] disp_seconds_q, disp_seconds_d;
  logic       adjust_mode_q, adjust_mode_d;
  logic       alarm_active_q, alarm_active_d;

  // Time after one 1 Hz tick, with seconds->minutes->hours carry.
  logic [5:0] tk_sec;
  logic [5:0] tk_min;
  logic [4:0] tk_hr;
  logic       trigger;
  logic       any_btn;
  logic [7:0] timer_inc;

  // State register and all output flops.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q        <= ST_CLOCK;
      sec_q          <= 6'd0;
      min_q          <= 6'd0;
      hr_q           <= 5'd0;
      al_min_q       <= 6'd0;
      al_hr_q        <= 5'd0;
      sel_q          <= 2'd0;
      timer_q        <= 8'd0;
      disp_hours_q   <= 5'd0;
      disp_minutes_q <= 6'd0;
      disp_seconds_q <= 6'd0;
      adjust_mode_q  <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sec_q          <= sec_d;
      min_q          <= min_d;
      hr_q           <= hr_d;
      al_min_q       <= al_min_d;
      al_hr_q        <= al_hr_d;
      sel_q          <= sel_d;
      timer_q        <= timer_d;
      disp_hours_q   <= disp_hours_d;
      disp_minutes_q <= disp_minutes_d;
      disp_seconds_q <= disp_seconds_d;
      adjust_mode_q  <= adjust_mode_d;
      alarm_active_q <= alarm_active_d;
    end
  end

  // Ticked time, alarm match and helper terms.
  always_comb begin
    tk_sec = sec_q;
    tk_min = min_q;
    tk_hr  = hr_q;
    if (sec_q >= 6'd59) begin
      tk_sec = 6'd0;
      if (min_q >= 6'd59) begin
        tk_min = 6'd0;
        tk_hr  = hr_inc(hr_q);
      end else begin
        tk_min = min_q + 6'd1;
      end
    end else begin
      tk_sec = sec_q + 6'd1;
    end
    // The alarm fires only on the tick that lands exactly on hh:mm:00.
    trigger   = bus.alarm_en & bus.en_1hz & (tk_sec == 6'd0) &
                (tk_min == al_min_q) & (tk_hr == al_hr_q);
    any_btn   = bus.btn_center | bus.btn_up | bus.btn_down |
                bus.btn_left | bus.btn_right;
    timer_inc = timer_q + 8'd1;
  end

  // Next-state logic; button priority center > left > right > up > down.
  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    sel_d    = sel_q;
    timer_d  = timer_q;
    case (state_q)
      ST_CLOCK: begin
        if (bus.en_1hz) begin
          sec_d = tk_sec;
          min_d = tk_min;
          hr_d  = tk_hr;
        end else begin
          sec_d = sec_q;
        end
        // Center beats a coincident trigger; the tick above is kept for
        // minutes/hours but seconds restart at zero.
        if (bus.btn_center) begin
          state_d = ST_ADJUST;
          sel_d   = 2'd0;
          sec_d   = 6'd0;
        end else if (trigger) begin
          state_d = ST_ALARM;
          timer_d = 8'd0;
        end else begin
          state_d = ST_CLOCK;
        end
      end
      ST_ADJUST: begin
        // Time is frozen here: en_1hz is ignored.
        if (bus.btn_center) begin
          state_d = ST_CLOCK;
          sec_d   = 6'd0;
        end else if (bus.btn_left) begin
          sel_d = sel_q - 2'd1;
        end else if (bus.btn_right) begin
          sel_d = sel_q + 2'd1;
        end else if (bus.btn_up) begin
          case (sel_q)
            2'd0:    hr_d     = hr_inc(hr_q);
            2'd1:    min_d    = min_inc(min_q);
            2'd2:    al_hr_d  = hr_inc(al_hr_q);
            2'd3:    al_min_d = min_inc(al_min_q);
            default: sel_d    = 2'd0;
          endcase
        end else if (bus.btn_down) begin
          case (sel_q)
            2'd0:    hr_d     = hr_dec(hr_q);
            2'd1:    min_d    = min_dec(min_q);
            2'd2:    al_hr_d  = hr_dec(al_hr_q);
            2'd3:    al_min_d = min_dec(al_min_q);
            default: sel_d    = 2'd0;
          endcase
        end else begin
          state_d = ST_ADJUST;
        end
      end
      ST_ALARM: begin
        if (bus.en_1hz) begin
          sec_d = tk_sec;
          min_d = tk_min;
          hr_d  = tk_hr;
        end else begin
          sec_d = sec_q;
        end
        // Any button or disarming dismisses; otherwise time out on ticks.
        if (any_btn || !bus.alarm_en) begin
          state_d = ST_CLOCK;
          timer_d = 8'd0;
        end else if (bus.en_1hz) begin
          if (timer_inc >= ALARM_LIMIT) begin
            state_d = ST_CLOCK;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_inc;
          end
        end else begin
          state_d = ST_ALARM;
        end
      end
      default: begin
        state_d = ST_CLOCK;
        timer_d = 8'd0;
      end
    endcase
  end

  // Output logic, computed from next state so the registered outputs
  // track the state one cycle after the causing input.
  always_comb begin
    adjust_mode_d  = (state_d == ST_ADJUST);
    alarm_active_d = (state_d == ST_ALARM);
    disp_seconds_d = sec_d;
    if (state_d == ST_ADJUST && sel_d[1]) begin
      disp_hours_d   = al_hr_d;
      disp_minutes_d = al_min_d;
    end else begin
      disp_hours_d   = hr_d;
      disp_minutes_d = min_d;
    end
  end

  assign bus.disp_hours   = disp_hours_q;
  assign bus.disp_minutes = disp_minutes_q;
  assign bus.disp_seconds = disp_seconds_q;
  assign bus.adjust_mode  = adjust_mode_q;
  assign bus.sel          = sel_q;
  assign bus.alarm_active = alarm_active_q;

endmodule

// File: tb/tb_alarm_clock_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_clock_controller
// Directed bench for alarm_clock_controller. Inputs change 1 ns after the
// rising edge and outputs are checked at that same point, i.e. one cycle
// after the input was presented.
// ---------------------------------------------------------------------------
module tb_alarm_clock_controller;

  logic clock;
  logic rst;
  int   total;
  int   bad;

  alarm_clock_controller_if bus ();

  alarm_clock_controller #(.ALARM_SECONDS(60)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check_val({tag, ".hh"}, int'(bus.disp_hours), h);
    check_val({tag, ".mm"}, int'(bus.disp_minutes), m);
    check_val({tag, ".ss"}, int'(bus.disp_seconds), s);
  endtask

  // One clock; all pulses are single-cycle so they drop afterwards.
  task automatic cyc();
    @(posedge clock);
    #1;
    bus.en_1hz     = 1'b0;
    bus.btn_center = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.en_1hz = 1'b1;
      cyc();
    end
  endtask

  // b: 0=center 1=up 2=down 3=left 4=right
  task automatic press(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      case (b)
        0:       bus.btn_center = 1'b1;
        1:       bus.btn_up     = 1'b1;
        2:       bus.btn_down   = 1'b1;
        3:       bus.btn_left   = 1'b1;
        default: bus.btn_right  = 1'b1;
      endcase
      cyc();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.en_1hz     = 1'b0;
    bus.btn_center = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.alarm_en   = 1'b0;
    cyc();
    do_reset();

    // Reset state
    check_time("rst", 0, 0, 0);
    check_val("rst.adj", int'(bus.adjust_mode), 0);
    check_val("rst.sel", int'(bus.sel), 0);
    check_val("rst.alarm", int'(bus.alarm_active), 0);

    // 3661 s = 01:01:01
    ticks(3661);
    check_time("count3661", 1, 1, 1);

    // Preload 23:59 via ADJUST, with wrap checks
    press(0, 1);
    check_val("adj.enter", int'(bus.adjust_mode), 1);
    check_val("adj.secclr", int'(bus.disp_seconds), 0);
    press(2, 2);                                   // hours 1 -> 0 -> 23
    check_val("hr.dec.wrap", int'(bus.disp_hours), 23);
    press(4, 1);                                   // sel 1
    press(2, 2);                                   // minutes 1 -> 0 -> 59
    check_val("min.dec.wrap", int'(bus.disp_minutes), 59);
    press(1, 1);                                   // minutes 59 -> 0
    check_val("min.inc.wrap", int'(bus.disp_minutes), 0);
    check_val("min.inc.nocarry", int'(bus.disp_hours), 23);
    press(2, 1);                                   // back to 59
    press(0, 1);
    check_val("adj.exit", int'(bus.adjust_mode), 0);
    check_time("preload", 23, 59, 0);
    ticks(59);
    check_time("235959", 23, 59, 59);
    ticks(1);
    check_time("midnight", 0, 0, 0);

    // center, down, up, up x5, sel wrap, right, up x3, ticks frozen, center
    do_reset();
    press(0, 1);
    press(2, 1);
    check_val("hr0.down", int'(bus.disp_hours), 23);
    press(1, 1);
    press(1, 5);
    check_val("hr.up5", int'(bus.disp_hours), 5);
    press(3, 1);
    check_val("sel.left.wrap", int'(bus.sel), 3);
    check_val("mux.alarm.hh", int'(bus.disp_hours), 0);
    press(4, 1);
    check_val("sel.right.wrap", int'(bus.sel), 0);
    check_val("mux.clock.hh", int'(bus.disp_hours), 5);
    press(4, 1);
    press(1, 3);
    ticks(3);
    check_time("adj.frozen", 5, 3, 0);
    press(0, 1);
    check_val("adj.exit2", int'(bus.adjust_mode), 0);
    check_time("0503", 5, 3, 0);

    // Alarm at 00:02
    do_reset();
    press(0, 1);
    press(3, 1);                                   // sel 3
    press(1, 2);
    check_val("al.mm.set", int'(bus.disp_minutes), 2);
    press(0, 1);
    bus.alarm_en = 1'b1;
    ticks(119);
    check_val("al.before", int'(bus.alarm_active), 0);
    check_time("al.before.t", 0, 1, 59);
    ticks(1);
    check_val("al.rise", int'(bus.alarm_active), 1);
    check_time("al.rise.t", 0, 2, 0);
    ticks(59);
    check_val("al.hold59", int'(bus.alarm_active), 1);
    ticks(1);
    check_val("al.timeout", int'(bus.alarm_active), 0);
    check_val("al.timeout.mm", int'(bus.disp_minutes), 3);

    // Alarm at 00:04, dismissed by btn_up
    press(0, 1);                                   // time 00:03:00
    press(3, 1);
    check_val("al.mm.show", int'(bus.disp_minutes), 2);
    press(1, 2);
    press(0, 1);
    ticks(59);
    check_val("al2.before", int'(bus.alarm_active), 0);
    ticks(1);
    check_val("al2.rise", int'(bus.alarm_active), 1);
    ticks(5);
    press(1, 1);
    check_val("al2.dismiss", int'(bus.alarm_active), 0);
    check_val("al2.dismiss.adj", int'(bus.adjust_mode), 0);
    check_time("al2.dismiss.t", 0, 4, 5);

    // Priority: center+up in CLOCK, left+right in ADJUST
    bus.btn_center = 1'b1;
    bus.btn_up     = 1'b1;
    cyc();
    check_val("prio.cu.adj", int'(bus.adjust_mode), 1);
    check_val("prio.cu.hh", int'(bus.disp_hours), 0);
    check_val("prio.cu.ss", int'(bus.disp_seconds), 0);
    bus.btn_left  = 1'b1;
    bus.btn_right = 1'b1;
    cyc();
    check_val("prio.lr.sel", int'(bus.sel), 3);

    // Alarm 07:30 with sel=2, then reset mid-ADJUST
    press(3, 1);                                   // sel 2
    press(1, 7);
    press(4, 1);                                   // sel 3, minutes 4
    press(1, 26);
    check_val("al730.hh", int'(bus.disp_hours), 7);
    check_val("al730.mm", int'(bus.disp_minutes), 30);
    press(3, 1);
    check_val("al730.sel", int'(bus.sel), 2);
    do_reset();
    check_val("rstadj.adj", int'(bus.adjust_mode), 0);
    check_val("rstadj.sel", int'(bus.sel), 0);
    check_val("rstadj.alarm", int'(bus.alarm_active), 0);
    check_time("rstadj", 0, 0, 0);
    press(0, 1);
    press(3, 2);                                   // sel 2: show alarm time
    check_val("rstadj.al.hh", int'(bus.disp_hours), 0);
    check_val("rstadj.al.mm", int'(bus.disp_minutes), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
